// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer: opcode width and encodings.
package microseq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_CONT  = 3'b000;
    localparam logic [OP_W-1:0] OP_JMP   = 3'b001;
    localparam logic [OP_W-1:0] OP_CJMP  = 3'b010;
    localparam logic [OP_W-1:0] OP_CALL  = 3'b011;
    localparam logic [OP_W-1:0] OP_CCALL = 3'b100;
    localparam logic [OP_W-1:0] OP_RET   = 3'b101;
    localparam logic [OP_W-1:0] OP_LDCNT = 3'b110;
    localparam logic [OP_W-1:0] OP_DJNZ  = 3'b111;

endpackage

// File: rtl/microseq_ras_controller_if.sv
// Microinstruction fields going into the sequencer and the sequencer status
// coming back. master = microinstruction source, slave = sequencer.
interface microseq_ras_controller_if #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int NUM_COND    = 4,
    parameter int CNT_W       = 8
);
    import microseq_pkg::*;

    localparam int SEL_W = $clog2(NUM_COND);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    logic              hold;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] brn_addr;
    logic [SEL_W-1:0]  cond_sel;
    logic              polarity;
    logic [NUM_COND-1:0] cond;

    logic [ADDR_W-1:0] upc;
    logic [SP_W-1:0]   sp;
    logic [CNT_W-1:0]  loop_cnt;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output hold, op, brn_addr, cond_sel, polarity, cond,
        input  upc, sp, loop_cnt, err_overflow, err_underflow
    );

    modport slave (
        input  hold, op, brn_addr, cond_sel, polarity, cond,
        output upc, sp, loop_cnt, err_overflow, err_underflow
    );

endinterface

// File: rtl/microseq_ras_controller_ras.sv
// Return-address stack for the sequencer. LIFO: push writes entry[sp], top
// is entry[sp-1]. Push when full and pop when empty are ignored here; the
// caller raises the matching error flag.
module microseq_ras #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               full,
    output logic                               empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] entries_r [STACK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic              full_s;
    logic              empty_s;
    logic [ADDR_W-1:0] top_s;

    assign full_s  = (sp_r == SP_W'(STACK_DEPTH));
    assign empty_s = (sp_r == SP_W'(0));

    // Occupancy counter; entry contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_r <= SP_W'(0);
        end else if (push && !full_s) begin
            sp_r <= sp_r + SP_W'(1);
        end else if (pop && !empty_s) begin
            sp_r <= sp_r - SP_W'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Write the return address into the first free slot.
    always_ff @(posedge clk) begin
        if (push && !full_s) begin
            entries_r[IDX_W'(sp_r)] <= push_data;
        end
    end

    // Top-of-stack read; drives zero when empty so nothing undefined leaks out.
    always_comb begin
        top_s = {ADDR_W{1'b0}};
        if (empty_s) begin
            top_s = {ADDR_W{1'b0}};
        end else begin
            top_s = entries_r[IDX_W'(sp_r - SP_W'(1))];
        end
    end

    assign top   = top_s;
    assign sp    = sp_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/microseq_ras_controller.sv
// Microprogram sequencer: computes the next control-store address from the
// current microinstruction (jumps, calls/returns through a return-address
// stack, and a single hardware loop counter). upc is fully registered.
module microseq_ras_controller
    import microseq_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int NUM_COND    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    microseq_ras_controller_if.slave   bus
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] upc_r;
    logic [CNT_W-1:0]  loop_cnt_r;
    logic              err_ovf_r;
    logic              err_unf_r;

    logic [ADDR_W-1:0] upc_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              ovf_nxt_s;
    logic              unf_nxt_s;
    logic [ADDR_W-1:0] inc_s;
    logic              cond_true_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] top_s;
    logic [SP_W-1:0]   sp_s;
    logic              full_s;
    logic              empty_s;

    // Sequential address wraps naturally at 2^ADDR_W.
    assign inc_s = upc_r + ADDR_W'(1);

    // Condition select; an out-of-range select reads as a constant 0 before polarity.
    always_comb begin
        cond_true_s = bus.polarity;
        if (32'(bus.cond_sel) < NUM_COND) begin
            cond_true_s = bus.cond[bus.cond_sel] ^ bus.polarity;
        end else begin
            cond_true_s = bus.polarity;
        end
    end

    // Next-address, counter and error-flag decode for the current opcode.
    always_comb begin
        upc_nxt_s = inc_s;
        cnt_nxt_s = loop_cnt_r;
        ovf_nxt_s = err_ovf_r;
        unf_nxt_s = err_unf_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (bus.op)
            OP_CONT: begin
                upc_nxt_s = inc_s;
            end
            OP_JMP: begin
                upc_nxt_s = bus.brn_addr;
            end
            OP_CJMP: begin
                if (cond_true_s) begin
                    upc_nxt_s = bus.brn_addr;
                end else begin
                    upc_nxt_s = inc_s;
                end
            end
            OP_CALL, OP_CCALL: begin
                if ((bus.op == OP_CCALL) && !cond_true_s) begin
                    upc_nxt_s = inc_s;
                end else if (!full_s) begin
                    push_s    = 1'b1;
                    upc_nxt_s = bus.brn_addr;
                end else begin
                    ovf_nxt_s = 1'b1;
                    upc_nxt_s = inc_s;
                end
            end
            OP_RET: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    upc_nxt_s = top_s;
                end else begin
                    unf_nxt_s = 1'b1;
                    upc_nxt_s = inc_s;
                end
            end
            OP_LDCNT: begin
                cnt_nxt_s = bus.brn_addr[CNT_W-1:0];
                upc_nxt_s = inc_s;
            end
            OP_DJNZ: begin
                if (loop_cnt_r != CNT_W'(0)) begin
                    cnt_nxt_s = loop_cnt_r - CNT_W'(1);
                    upc_nxt_s = bus.brn_addr;
                end else begin
                    upc_nxt_s = inc_s;
                end
            end
            default: begin
                upc_nxt_s = inc_s;
            end
        endcase
    end

    // Sequencer state; reset beats hold, hold freezes everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            upc_r      <= ADDR_W'(0);
            loop_cnt_r <= CNT_W'(0);
            err_ovf_r  <= 1'b0;
            err_unf_r  <= 1'b0;
        end else if (!bus.hold) begin
            upc_r      <= upc_nxt_s;
            loop_cnt_r <= cnt_nxt_s;
            err_ovf_r  <= ovf_nxt_s;
            err_unf_r  <= unf_nxt_s;
        end else begin
            upc_r      <= upc_r;
            loop_cnt_r <= loop_cnt_r;
            err_ovf_r  <= err_ovf_r;
            err_unf_r  <= err_unf_r;
        end
    end

    microseq_ras #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s && !bus.hold),
        .pop       (pop_s && !bus.hold),
        .push_data (inc_s),
        .top       (top_s),
        .sp        (sp_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign bus.upc           = upc_r;
    assign bus.sp            = sp_s;
    assign bus.loop_cnt      = loop_cnt_r;
    assign bus.err_overflow  = err_ovf_r;
    assign bus.err_underflow = err_unf_r;

endmodule

// File: tb/tb_microseq_ras_controller.sv
// Directed self-checking bench for microseq_ras_controller.
module tb_microseq_ras_controller;
    import microseq_pkg::*;

    localparam int ADDR_W      = 11;
    localparam int STACK_DEPTH = 4;
    localparam int NUM_COND    = 4;
    localparam int CNT_W       = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    microseq_ras_controller_if #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .NUM_COND(NUM_COND), .CNT_W(CNT_W)
    ) bus ();

    microseq_ras_controller #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .NUM_COND(NUM_COND), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [10:0] a);
        bus.op       = o;
        bus.brn_addr = a;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.hold = 1'b0;
        bus.cond = 4'b0000;
        bus.cond_sel = 2'd0;
        bus.polarity = 1'b0;
        drive(OP_CONT, 11'h000);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.upc !== 11'h000) begin errors++; $display("FAIL reset_upc: got %h expected %h", bus.upc, 11'h000); end
        checks++; if (bus.sp !== 3'd0) begin errors++; $display("FAIL reset_sp: got %0d expected 0", bus.sp); end
        checks++; if (bus.loop_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected 00", bus.loop_cnt); end
        checks++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.err_overflow, bus.err_underflow}); end
        drive(OP_CONT, 11'h000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.upc !== 11'(i) || bus.sp !== 3'd0) begin errors++; $display("FAIL cont_seq[%0d]: got upc=%h sp=%0d expected upc=%h sp=0", i, bus.upc, bus.sp, 11'(i)); end
        end
        reset = 1'b0;
        tick();
        checks++; if (bus.upc !== 11'h000) begin errors++; $display("FAIL midrun_reset: got %h expected 000", bus.upc); end
        reset = 1'b1;
    endtask

    task automatic test_cond_branch();
        do_reset();
        bus.cond = 4'b0100; bus.cond_sel = 2'd2; bus.polarity = 1'b0;
        drive(OP_CJMP, 11'h040);
        tick();
        checks++; if (bus.upc !== 11'h040) begin errors++; $display("FAIL cjmp_taken: got %h expected 040", bus.upc); end
        bus.polarity = 1'b1;
        tick();
        checks++; if (bus.upc !== 11'h041) begin errors++; $display("FAIL cjmp_inv_not_taken: got %h expected 041", bus.upc); end
        bus.cond_sel = 2'd1; bus.polarity = 1'b0;
        tick();
        checks++; if (bus.upc !== 11'h042) begin errors++; $display("FAIL cjmp_sel1_not_taken: got %h expected 042", bus.upc); end
        bus.polarity = 1'b1;
        tick();
        checks++; if (bus.upc !== 11'h040) begin errors++; $display("FAIL cjmp_sel1_inv_taken: got %h expected 040", bus.upc); end
        bus.cond_sel = 2'd2; bus.polarity = 1'b1;
        drive(OP_CCALL, 11'h080);
        tick();
        checks++; if (bus.upc !== 11'h041 || bus.sp !== 3'd0) begin errors++; $display("FAIL ccall_false: got upc=%h sp=%0d expected upc=041 sp=0", bus.upc, bus.sp); end
        bus.polarity = 1'b0;
        tick();
        checks++; if (bus.upc !== 11'h080 || bus.sp !== 3'd1) begin errors++; $display("FAIL ccall_true: got upc=%h sp=%0d expected upc=080 sp=1", bus.upc, bus.sp); end
        drive(OP_RET, 11'h000);
        tick();
        checks++; if (bus.upc !== 11'h042 || bus.sp !== 3'd0) begin errors++; $display("FAIL ccall_ret: got upc=%h sp=%0d expected upc=042 sp=0", bus.upc, bus.sp); end
    endtask

    task automatic test_nested_calls();
        logic [2:0]  ops [4];
        logic [10:0] addrs [4];
        logic [10:0] exp_upc [4];
        logic [2:0]  exp_sp [4];
        ops = '{OP_CALL, OP_CALL, OP_RET, OP_RET};
        addrs = '{11'h100, 11'h200, 11'h000, 11'h000};
        exp_upc = '{11'h100, 11'h200, 11'h101, 11'h004};
        exp_sp = '{3'd1, 3'd2, 3'd1, 3'd0};
        do_reset();
        drive(OP_CONT, 11'h000);
        tick(); tick(); tick();
        checks++; if (bus.upc !== 11'h003) begin errors++; $display("FAIL nest_start: got %h expected 003", bus.upc); end
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], addrs[i]);
            tick();
            checks++; if (bus.upc !== exp_upc[i] || bus.sp !== exp_sp[i]) begin errors++; $display("FAIL nest[%0d]: got upc=%h sp=%0d expected upc=%h sp=%0d", i, bus.upc, bus.sp, exp_upc[i], exp_sp[i]); end
        end
    endtask

    task automatic test_overflow_underflow();
        logic [10:0] exp_ret [4];
        exp_ret = '{11'h031, 11'h021, 11'h011, 11'h001};
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(OP_CALL, 11'(16 * i));
            tick();
            checks++; if (bus.upc !== 11'(16 * i) || bus.sp !== 3'(i)) begin errors++; $display("FAIL ovf_call[%0d]: got upc=%h sp=%0d expected upc=%h sp=%0d", i, bus.upc, bus.sp, 11'(16 * i), i); end
        end
        checks++; if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", bus.err_overflow); end
        drive(OP_CALL, 11'h050);
        tick();
        checks++; if (bus.upc !== 11'h041 || bus.sp !== 3'd4 || bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_fifth: got upc=%h sp=%0d ovf=%b expected upc=041 sp=4 ovf=1", bus.upc, bus.sp, bus.err_overflow); end
        drive(OP_RET, 11'h000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.upc !== exp_ret[i] || bus.sp !== 3'(3 - i)) begin errors++; $display("FAIL ovf_ret[%0d]: got upc=%h sp=%0d expected upc=%h sp=%0d", i, bus.upc, bus.sp, exp_ret[i], 3 - i); end
        end
        tick();
        checks++; if (bus.upc !== 11'h002 || bus.sp !== 3'd0 || bus.err_underflow !== 1'b1) begin errors++; $display("FAIL unf_ret: got upc=%h sp=%0d unf=%b expected upc=002 sp=0 unf=1", bus.upc, bus.sp, bus.err_underflow); end
        drive(OP_CONT, 11'h000);
        tick();
        checks++; if (bus.upc !== 11'h003 || {bus.err_overflow, bus.err_underflow} !== 2'b11) begin errors++; $display("FAIL flags_sticky: got upc=%h flags=%b expected upc=003 flags=11", bus.upc, {bus.err_overflow, bus.err_underflow}); end
    endtask

    task automatic test_loop();
        logic [10:0] exp_upc [4];
        logic [7:0]  exp_cnt [4];
        exp_upc = '{11'h001, 11'h001, 11'h001, 11'h002};
        exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd0};
        do_reset();
        drive(OP_LDCNT, 11'h303);
        tick();
        checks++; if (bus.upc !== 11'h001 || bus.loop_cnt !== 8'h03) begin errors++; $display("FAIL ldcnt: got upc=%h cnt=%h expected upc=001 cnt=03", bus.upc, bus.loop_cnt); end
        drive(OP_DJNZ, 11'h001);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.upc !== exp_upc[i] || bus.loop_cnt !== exp_cnt[i]) begin errors++; $display("FAIL djnz[%0d]: got upc=%h cnt=%0d expected upc=%h cnt=%0d", i, bus.upc, bus.loop_cnt, exp_upc[i], exp_cnt[i]); end
        end
    endtask

    task automatic test_hold_wrap();
        do_reset();
        drive(OP_CALL, 11'h100);
        tick();
        checks++; if (bus.upc !== 11'h100 || bus.sp !== 3'd1) begin errors++; $display("FAIL hold_precall: got upc=%h sp=%0d expected upc=100 sp=1", bus.upc, bus.sp); end
        bus.hold = 1'b1;
        drive(OP_CALL, 11'h300);
        tick(); tick();
        checks++; if (bus.upc !== 11'h100 || bus.sp !== 3'd1) begin errors++; $display("FAIL hold_frozen: got upc=%h sp=%0d expected upc=100 sp=1", bus.upc, bus.sp); end
        bus.hold = 1'b0;
        drive(OP_RET, 11'h000);
        tick();
        checks++; if (bus.upc !== 11'h001 || bus.sp !== 3'd0) begin errors++; $display("FAIL hold_stack_intact: got upc=%h sp=%0d expected upc=001 sp=0", bus.upc, bus.sp); end
        bus.hold = 1'b1;
        reset = 1'b0;
        tick();
        checks++; if (bus.upc !== 11'h000) begin errors++; $display("FAIL reset_over_hold: got %h expected 000", bus.upc); end
        bus.hold = 1'b0;
        reset = 1'b1;
        drive(OP_JMP, 11'h7FF);
        tick();
        checks++; if (bus.upc !== 11'h7FF) begin errors++; $display("FAIL jmp_max: got %h expected 7ff", bus.upc); end
        drive(OP_CONT, 11'h000);
        tick();
        checks++; if (bus.upc !== 11'h000) begin errors++; $display("FAIL wrap: got %h expected 000", bus.upc); end
    endtask

    initial begin
        reset = 1'b0;
        bus.hold = 1'b0;
        bus.cond = 4'b0000;
        bus.cond_sel = 2'd0;
        bus.polarity = 1'b0;
        bus.op = OP_CONT;
        bus.brn_addr = 11'h000;
        test_reset();
        test_cond_branch();
        test_nested_calls();
        test_overflow_underflow();
        test_loop();
        test_hold_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microseq_ras_controller.md
Name: microseq_ras_controller

Overview:
Parametrised microprogram sequencer for the lab controller datapath. Generates the control-store address (upc) each cycle from the current microinstruction fields. Supports unconditional and conditional jumps, conditional calls with an N-deep nested return-address stack, returns, and a hardware loop counter. Sits between the control store (asynchronous ROM read of upc) and the datapath that consumes the microinstruction.

Parameters:
ADDR_W, 11, control-store address width (upc, brn_addr, stack entries)
STACK_DEPTH, 4, return-address stack entries (>=2, power of two not required)
NUM_COND, 4, number of condition inputs selectable by cond_sel
CNT_W, 8, loop counter width (CNT_W <= ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
hold  in  1  1 = freeze all state (upc, stack, sp, counter, flags)
op  in  3  sequencer opcode of current microinstruction
brn_addr  in  ADDR_W  branch/call target; low CNT_W bits are the count for LDCNT
cond_sel  in  $clog2(NUM_COND)  condition select
polarity  in  1  1 = invert selected condition
cond  in  NUM_COND  status flags from datapath
upc  out  ADDR_W  current control-store address (registered)
sp  out  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH
loop_cnt  out  CNT_W  current loop counter value
err_overflow  out  1  sticky: call attempted with stack full
err_underflow  out  1  sticky: return attempted with stack empty

Behaviour:
- Reset (reset==0 at clk edge): upc=0, sp=0, loop_cnt=0, both error flags=0; stack contents don't-care. Reset has priority over hold.
- hold==1 (not in reset): no state changes; outputs stable.
- cond_true = cond[cond_sel] ^ polarity; cond_sel >= NUM_COND gives cond_true = polarity.
- inc = upc+1, modulo 2^ADDR_W (max address wraps to 0).
- Opcodes (next-state on edge, hold==0):
  000 CONT: upc<=inc.
  001 JMP: upc<=brn_addr.
  010 CJMP: upc<=cond_true ? brn_addr : inc.
  011 CALL: if sp<STACK_DEPTH: push inc, sp+=1, upc<=brn_addr; else upc<=inc, err_overflow<=1, stack unchanged.
  100 CCALL: cond_true -> same as CALL; else upc<=inc.
  101 RET: if sp>0: upc<=top, sp-=1; else upc<=inc, err_underflow<=1.
  110 LDCNT: loop_cnt<=brn_addr[CNT_W-1:0], upc<=inc.
  111 DJNZ: if loop_cnt!=0: loop_cnt-=1, upc<=brn_addr; else upc<=inc, counter stays 0.
- Latency: one cycle from op presentation to new upc; upc is registered, with no combinational path from inputs to upc.
- Stack is LIFO; push writes entry[sp], pop reads entry[sp-1]. Nesting depth up to STACK_DEPTH is lossless.
- Error flags are sticky until reset; the sequencer keeps running after an error.
- Loop counter is single (not stacked); nested loops are the microprogrammer's responsibility.

Decomposition:
- Shared package microseq_pkg: opcode localparams (OP_CONT..OP_DJNZ) and the 3-bit opcode width.
- Sub-module microseq_ras: return-address stack (push, pop, top, sp, full, empty), parametrised by ADDR_W and STACK_DEPTH, with the same synchronous active-low reset on sp.
- Condition select, next-address mux and upc register stay in the top module.

Test Plan:
- Reset and sequencing: reset low 2 cycles, then op=CONT x5 -> upc 0,1,2,3,4,5; sp=0, flags 0; reset asserted mid-run at upc=5 -> upc=0 next edge.
- Conditional branch: cond=4'b0100, cond_sel=2, polarity=0, op=CJMP, brn_addr=0x40 -> upc=0x40; repeat with polarity=1 -> upc=inc.
- Nested calls: CALL 0x100 at upc=3, CALL 0x200 at 0x100, RET, RET -> upc sequence 0x100, 0x200, 0x101, 4; sp 1,2,1,0.
- Overflow/underflow: 5 CALLs with STACK_DEPTH=4 -> 5th gives upc=inc, sp stays 4, err_overflow=1; RET at sp=0 -> upc=inc, err_underflow=1, flag persists.
- Loop: LDCNT brn_addr=3, then DJNZ to its own address -> jumps 3 times (loop_cnt 2,1,0), falls through on 4th execution.
- Hold and wrap: hold=1 during CALL -> no change to upc, sp or stack; upc=0x7FF with CONT -> upc=0x000.
